demux_fifo: RTL and testbench

Registered 1-to-N demultiplexer: accepts one valid/ready input stream tagged with a channel select and delivers each word to one of N = 2^switch_bits output channels. Each channel has its own 2-entry FIFO, so a stalled channel blocks only words addressed to it. It is the counterpart of the n-way mux tree in the shared primitives: it fans one producer out to N consumers, such as per-neuron or per-layer input ports.

---
 rtl/demux_fifo.sv | 73 +++++++
 tb/tb_demux_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/demux_fifo.sv
// demux_fifo: registered 1-to-N valid/ready demultiplexer.
// Each output channel has its own 2-entry FIFO.
`default_nettype none

module demux_fifo #(
  parameter int switch_bits = 2,
  parameter int data_width  = 8,
  localparam int N = 1 << switch_bits
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [switch_bits-1:0]  in_sel,
  input  logic [data_width-1:0]   in_data,
  output logic [N-1:0]            out_valid,
  input  logic [N-1:0]            out_ready,
  output logic [N*data_width-1:0] out_data
);

  logic [1:0] occ_all [N];
  logic       push;

  // Readiness looks only at the addressed channel, so a full channel never
  // stalls words bound elsewhere.
  assign in_ready = rst && (occ_all[in_sel] != 2'd2);
  assign push     = in_valid && in_ready;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [1:0]            occ;
    logic [data_width-1:0] head;
    logic [data_width-1:0] tail;
    logic                  push_ch;
    logic                  pop_ch;

    assign push_ch = push && (in_sel == switch_bits'(i));
    assign pop_ch  = (occ != 2'd0) && out_ready[i];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        occ  <= 2'd0;
        head <= '0;
        tail <= '0;
      end else begin
        case ({push_ch, pop_ch})
          2'b10: begin
            if (occ == 2'd0) begin
              head <= in_data;
              occ  <= 2'd1;
            end else begin
              tail <= in_data;
              occ  <= 2'd2;
            end
          end
          2'b01: begin
            if (occ == 2'd2) head <= tail;
            occ <= occ - 2'd1;
          end
          // Push and pop together only happen at occupancy 1: replace the head.
          2'b11: head <= in_data;
          default: ;
        endcase
      end
    end

    assign occ_all[i]                           = occ;
    assign out_valid[i]                         = (occ != 2'd0);
    assign out_data[i*data_width +: data_width] = head;
  end

endmodule

`default_nettype wire

// File: tb/tb_demux_fifo.sv
// tb_demux_fifo: directed stimulus with per-channel scoreboard queues and
// an independent monitor comparing every popped word.
`default_nettype none

module tb_demux_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [7:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [4][$];

  demux_fifo #(.switch_bits(2), .data_width(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer a word; it is recorded as expected once the handshake completes.
  task automatic send(input int ch, input logic [7:0] d, output int waits);
    bit done = 0;
    waits = 0;
    in_valid = 1'b1;
    in_sel   = 2'(ch);
    in_data  = d;
    while (!done && waits < 50) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else waits++;
      @(posedge clk);
    end
    if (done) sb[ch].push_back(d);
    else chk("send_timeout", 32'(ch), 32'hFFFF);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: compare every word leaving the DUT against its channel queue.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (sb[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected ch%0d: got %0h expected none", i, out_data[i*8 +: 8]);
          end else begin
            chk($sformatf("pop_ch%0d", i), 32'(out_data[i*8 +: 8]), 32'(sb[i].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    int w;
    int wsum;
    rst = 1'b0; in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h55; out_ready = 4'h0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // First push after reset
    send(2, 8'h11, w);
    chk("first_valid", 32'(out_valid), 32'b0100);
    chk("first_data", 32'(out_data[23:16]), 32'h11);
    out_ready = 4'b0100;
    cyc();
    out_ready = 4'h0;
    chk("first_drained", 32'(out_valid), 32'd0);

    // Fill and block channel 1
    send(1, 8'hA1, w);
    send(1, 8'hA2, w);
    in_sel = 2'd1; #1;
    chk("full_blocks", 32'(in_ready), 32'd0);
    in_sel = 2'd3; #1;
    chk("other_ready", 32'(in_ready), 32'd1);
    chk("full_head", 32'(out_data[15:8]), 32'hA1);
    in_sel = 2'd1;
    out_ready = 4'b0010;
    cyc();
    chk("ready_after_pop", 32'(in_ready), 32'd1);
    cyc();
    out_ready = 4'h0;
    chk("ch1_empty", 32'(out_valid), 32'd0);

    // Streaming push+pop on channel 0
    out_ready = 4'b0001;
    wsum = 0;
    for (int k = 0; k < 16; k++) begin
      send(0, 8'(k), w);
      wsum += w;
    end
    chk("stream_no_stall", 32'(wsum), 32'd0);
    cyc();
    out_ready = 4'h0;
    chk("stream_empty", 32'(out_valid), 32'd0);

    // Isolation: channel 3 stalled full
    out_ready = 4'b0111;
    send(3, 8'hC1, w);
    send(3, 8'hC2, w);
    wsum = 0;
    for (int k = 0; k < 9; k++) begin
      send(k % 3, 8'h30 + 8'(k), w);
      wsum += w;
    end
    chk("iso_no_stall", 32'(wsum), 32'd0);
    cyc();
    chk("iso_valid", 32'(out_valid), 32'b1000);
    chk("iso_ch3_head", 32'(out_data[31:24]), 32'hC1);
    in_sel = 2'd3; #1;
    chk("iso_ch3_full", 32'(in_ready), 32'd0);
    out_ready = 4'b1000;
    cyc();
    chk("iso_ch3_second", 32'(out_data[31:24]), 32'hC2);
    cyc();
    out_ready = 4'h0;

    // Multi-pop: every channel holding two words
    for (int c = 0; c < 4; c++) begin
      send(c, 8'(16 * c), w);
      send(c, 8'(16 * c + 1), w);
    end
    chk("multi_full", 32'(out_valid), 32'hF);
    out_ready = 4'hF;
    cyc();
    chk("multi_mid", 32'(out_valid), 32'hF);
    chk("multi_heads", out_data, 32'h31211101);
    cyc();
    out_ready = 4'h0;
    chk("multi_empty", 32'(out_valid), 32'd0);

    // Mid-operation asynchronous reset
    send(0, 8'h5A, w);
    send(1, 8'h5B, w);
    send(1, 8'h5C, w);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 4; c++) sb[c].delete();
    rst = 1'b1;
    cyc();
    cyc();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    send(1, 8'h77, w);
    chk("post_rst_data", 32'(out_data[15:8]), 32'h77);
    out_ready = 4'hF;
    cyc();
    out_ready = 4'h0;
    cyc();

    for (int c = 0; c < 4; c++) chk($sformatf("sb_empty_ch%0d", c), 32'(sb[c].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

`default_nettype wire
